// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state encoding and address helpers for the cache controller
// Purpose: state encoding for the cache sequencing FSM plus the line_align helper.
// Ports: none (package).
package cache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t LOOKUP    = 3'd1;
    localparam state_t READ      = 3'd2;
    localparam state_t WRITE     = 3'd3;
    localparam state_t FILL_REQ  = 3'd4;
    localparam state_t FILL_WAIT = 3'd5;
    localparam state_t REPLAY    = 3'd6;

    // Clears the byte-offset bits of an address. Works on a 64-bit container so
    // any address width up to 64 can use it; callers truncate the result.
    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned noffset);
        return addr & ~((64'd1 << noffset) - 64'd1);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - 32-bit event counter with synchronous clear
// Purpose: counts cycles where i_inc is high, wrapping modulo 2^32.
// Ports:
//   clock   in  1   rising-edge clock
//   reset   in  1   synchronous active-high clear
//   i_inc   in  1   increment enable
//   o_count out 32  current count
module perf_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - request sequencer in front of the line cache
// Purpose: accepts one line request at a time, looks up the cache, serves hits,
// fetches missing lines from memory and replays the lookup; counts hits/misses.
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   cpu_req_*                         CPU request (valid/ready/write/addr/wdata)
//   cpu_resp_valid, cpu_resp_rdata    one-cycle completion pulse with read line
//   mem_req_valid/ready/addr          line fetch request to backing memory
//   mem_resp_valid, mem_resp_data     fetched line, one cycle
//   cache_mem_write_en, cache_cpu_write_en, cache_address, cache_data_in  cache control
//   cache_data_out, cache_hit         cache read data (registered) and hit (combinational)
//   hit_count, miss_count             performance counters
module cache_controller
    import cache_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int LINE_SIZE = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_req_valid,
    output logic                   cpu_req_ready,
    input  logic                   cpu_req_write,
    input  logic [XLEN-1:0]        cpu_req_addr,
    input  logic [8*LINE_SIZE-1:0] cpu_req_wdata,
    output logic                   cpu_resp_valid,
    output logic [8*LINE_SIZE-1:0] cpu_resp_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [XLEN-1:0]        mem_req_addr,
    input  logic                   mem_resp_valid,
    input  logic [8*LINE_SIZE-1:0] mem_resp_data,
    output logic                   cache_mem_write_en,
    output logic                   cache_cpu_write_en,
    output logic [XLEN-1:0]        cache_address,
    output logic [8*LINE_SIZE-1:0] cache_data_in,
    input  logic [8*LINE_SIZE-1:0] cache_data_out,
    input  logic                   cache_hit,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);

    localparam int unsigned NOFFSET = $clog2(LINE_SIZE);

    state_t                 r_state;
    state_t                 w_next;
    logic [XLEN-1:0]        r_addr;
    logic                   r_write;
    logic [8*LINE_SIZE-1:0] r_wdata;
    logic                   w_accept;
    logic                   w_hit_inc;
    logic                   w_miss_inc;

    assign w_accept = cpu_req_valid && (r_state == IDLE);

    // Only the first lookup of a request counts; REPLAY is a guaranteed hit
    // and must not inflate the hit counter.
    assign w_hit_inc  = (r_state == LOOKUP) &&  cache_hit;
    assign w_miss_inc = (r_state == LOOKUP) && !cache_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= cpu_req_addr;
            r_write <= cpu_req_write;
            r_wdata <= cpu_req_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (cpu_req_valid) w_next = LOOKUP;
            LOOKUP,
            REPLAY:    begin
                if (cache_hit) begin
                    w_next = r_write ? WRITE : READ;
                end else begin
                    w_next = FILL_REQ;
                end
            end
            READ,
            WRITE:     w_next = IDLE;
            FILL_REQ:  if (mem_req_ready) w_next = FILL_WAIT;
            FILL_WAIT: if (mem_resp_valid) w_next = REPLAY;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready      = 1'b0;
        cpu_resp_valid     = 1'b0;
        cpu_resp_rdata     = '0;
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        cache_mem_write_en = 1'b0;
        cache_cpu_write_en = 1'b0;
        cache_data_in      = '0;
        // In IDLE the cache sees the incoming address so LOOKUP can sample the
        // hit and the registered data is ready by READ.
        cache_address      = (r_state == IDLE) ? cpu_req_addr : r_addr;
        case (r_state)
            IDLE:      cpu_req_ready = 1'b1;
            READ:      begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = cache_data_out;
            end
            WRITE:     begin
                cpu_resp_valid     = 1'b1;
                cache_cpu_write_en = 1'b1;
                cache_data_in      = r_wdata;
            end
            FILL_REQ:  begin
                mem_req_valid = 1'b1;
                mem_req_addr  = XLEN'(line_align(64'(r_addr), NOFFSET));
            end
            FILL_WAIT: begin
                if (mem_resp_valid) begin
                    cache_mem_write_en = 1'b1;
                    cache_data_in      = mem_resp_data;
                end
            end
            default:   ;
        endcase
    end

    perf_counter u_hit_counter (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_hit_inc),
        .o_count (hit_count)
    );

    perf_counter u_miss_counter (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_miss_inc),
        .o_count (miss_count)
    );

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
module tb_cache_controller;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic         cpu_req_write;
    logic [31:0]  cpu_req_addr;
    logic [511:0] cpu_req_wdata;
    logic         cpu_resp_valid;
    logic [511:0] cpu_resp_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;
    logic         cache_mem_write_en;
    logic         cache_cpu_write_en;
    logic [31:0]  cache_address;
    logic [511:0] cache_data_in;
    logic [511:0] cache_data_out = '0;
    logic         cache_hit;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks   = 0;
    int failures = 0;

    cache_controller #(.XLEN(32), .LINE_SIZE(64)) dut (
        .clock              (clock),
        .reset              (reset),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_req_write      (cpu_req_write),
        .cpu_req_addr       (cpu_req_addr),
        .cpu_req_wdata      (cpu_req_wdata),
        .cpu_resp_valid     (cpu_resp_valid),
        .cpu_resp_rdata     (cpu_resp_rdata),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .cache_mem_write_en (cache_mem_write_en),
        .cache_cpu_write_en (cache_cpu_write_en),
        .cache_address      (cache_address),
        .cache_data_in      (cache_data_in),
        .cache_data_out     (cache_data_out),
        .cache_hit          (cache_hit),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    always #5 clock = ~clock;

    // Behavioural line cache: 64-set direct-mapped, set = addr[11:6].
    logic         c_valid [64] = '{default: 1'b0};
    logic [19:0]  c_tag   [64] = '{default: 20'd0};
    logic [511:0] c_data  [64] = '{default: 512'd0};

    always_comb cache_hit = c_valid[cache_address[11:6]] &&
                            (c_tag[cache_address[11:6]] == cache_address[31:12]);

    always @(posedge clock) begin
        cache_data_out <= c_data[cache_address[11:6]];
        if (cache_mem_write_en) begin
            c_valid[cache_address[11:6]] <= 1'b1;
            c_tag[cache_address[11:6]]   <= cache_address[31:12];
            c_data[cache_address[11:6]]  <= cache_data_in;
        end else if (cache_cpu_write_en && cache_hit) begin
            c_data[cache_address[11:6]]  <= cache_data_in;
        end
    end

    function automatic logic [511:0] mempat(input logic [31:0] line);
        if (line == 32'h1040) return {64{8'hA5}};
        return {16{line ^ 32'h9E3779B9}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_l(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one request from IDLE to completion while acting as backing memory.
    // Returns to the caller one cycle after the response, with the DUT in IDLE.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [511:0] wd,
                           input int rdy_dly, input int rsp_dly, input bit hold, input bit spur,
                           output logic [511:0] rdata, output int lat, output int nfill,
                           output int nhs, output int nreq, output logic [31:0] maddr,
                           output bit ok_flags, output bit wstrobe_ok);
        int waitc;
        int resp_at;
        bit got;
        logic [31:0] first_addr;
        rdata = '0; lat = 0; nfill = 0; nhs = 0; nreq = 0; maddr = '0;
        ok_flags = 1'b1; wstrobe_ok = 1'b1; waitc = 0; resp_at = -1; got = 1'b0;
        first_addr = '0;
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = addr; cpu_req_wdata = wd;
        mem_req_ready = 1'b0;
        mem_resp_valid = spur; mem_resp_data = {16{32'hBAD0BAD0}};
        #1;
        if (spur) chk_i("spur_idle_no_fill", int'(cache_mem_write_en), 0);
        tick();
        for (int c = 1; c < 200 && !got; c++) begin
            cpu_req_valid = hold; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
            if (c == resp_at) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mempat(addr & ~32'h3F);
            end
            if (mem_req_valid) begin
                if (nreq == 0) first_addr = mem_req_addr;
                else if (mem_req_addr !== first_addr) ok_flags = 1'b0;
                nreq++;
                maddr = mem_req_addr;
                if (spur) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = {16{32'hBAD0BAD0}};
                end
                if (waitc >= rdy_dly) begin
                    mem_req_ready = 1'b1; nhs++; resp_at = c + 1 + rsp_dly;
                end else begin
                    waitc++;
                end
            end
            #1;
            if (cache_mem_write_en) nfill++;
            if (cache_mem_write_en && cache_cpu_write_en) ok_flags = 1'b0;
            if (cpu_req_ready) ok_flags = 1'b0;
            if (spur && mem_req_valid && cache_mem_write_en) ok_flags = 1'b0;
            if (cpu_resp_valid) begin
                got = 1'b1; lat = c; rdata = cpu_resp_rdata;
                if (wr && (!cache_cpu_write_en || cache_data_in !== wd)) wstrobe_ok = 1'b0;
                if (!wr && cache_cpu_write_en) wstrobe_ok = 1'b0;
            end else begin
                tick();
            end
        end
        cpu_req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        tick();
    endtask

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [511:0] wd;
        int           rdy;
        int           rsp;
        bit           hold;
        bit           spur;
        logic [511:0] exp_rdata;
        int           exp_lat;
        int           exp_fill;
        logic [31:0]  exp_maddr;
        int           exp_hits;
        int           exp_misses;
    } vec_t;

    vec_t vecs[6];

    // Higher-level model for the random phase: per-line contents and presence.
    logic [511:0] m_data    [logic [31:0]];
    bit           m_present [logic [31:0]];

    initial begin
        logic [511:0] rdata;
        int lat, nfill, nhs, nreq, k, nresp, last, m_hits, m_miss;
        logic [31:0] maddr;
        bit okf, wok, accepted;

        vecs[0] = '{1'b0, 32'h1044, '0, 0, 2, 1'b0, 1'b0, {64{8'hA5}}, 7, 1, 32'h1040, 0, 1};
        vecs[1] = '{1'b0, 32'h1070, '0, 0, 0, 1'b0, 1'b0, {64{8'hA5}}, 2, 0, 32'h0, 1, 1};
        vecs[2] = '{1'b1, 32'h1040, {64{8'h3C}}, 0, 0, 1'b0, 1'b0, '0, 2, 0, 32'h0, 2, 1};
        vecs[3] = '{1'b0, 32'h1040, '0, 0, 0, 1'b0, 1'b0, {64{8'h3C}}, 2, 0, 32'h0, 3, 1};
        vecs[4] = '{1'b0, 32'h5100, '0, 5, 0, 1'b1, 1'b0, mempat(32'h5100), 10, 1, 32'h5100, 3, 2};
        vecs[5] = '{1'b1, 32'h1C24, {16{32'h600DF00D}}, 2, 1, 1'b0, 1'b1, '0, 8, 1, 32'h1C00, 3, 3};

        reset = 1'b1; cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0;
        cpu_req_wdata = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk_i("reset_ready", int'(cpu_req_ready), 1);
        chk_i("reset_resp_valid", int'(cpu_resp_valid), 0);
        chk_i("reset_mem_req_valid", int'(mem_req_valid), 0);
        chk_i("reset_write_ens", int'({cache_mem_write_en, cache_cpu_write_en}), 0);
        chk_l("reset_data_in", cache_data_in, '0);
        chk_i("reset_hits", int'(hit_count), 0);
        chk_i("reset_misses", int'(miss_count), 0);
        tick();

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].rsp,
                    vecs[i].hold, vecs[i].spur, rdata, lat, nfill, nhs, nreq, maddr, okf, wok);
            chk_l($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk_i($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk_i($sformatf("v%0d_fill_writes", i), nfill, vecs[i].exp_fill);
            chk_i($sformatf("v%0d_mem_handshakes", i), nhs, vecs[i].exp_fill);
            chk_i($sformatf("v%0d_mem_req_cycles", i), nreq,
                  vecs[i].exp_fill * (vecs[i].rdy + 1));
            chk_i($sformatf("v%0d_mem_req_addr", i), int'(maddr), int'(vecs[i].exp_maddr));
            chk_i($sformatf("v%0d_protocol", i), int'(okf), 1);
            chk_i($sformatf("v%0d_write_strobe", i), int'(wok), 1);
            chk_i($sformatf("v%0d_hits", i), int'(hit_count), vecs[i].exp_hits);
            chk_i($sformatf("v%0d_misses", i), int'(miss_count), vecs[i].exp_misses);
            chk_i($sformatf("v%0d_idle_after", i), int'(cpu_req_ready), 1);
        end

        // Reset while waiting for the fill; the late response must be ignored.
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h6180;
        tick();
        cpu_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk_i("rst_fillreq_valid", int'(mem_req_valid), 1);
        tick();
        mem_req_ready = 1'b0;
        #1;
        chk_i("rst_req_drops", int'(mem_req_valid), 0);
        chk_i("rst_pre_misses", int'(miss_count), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = mempat(32'h6180);
        #1;
        chk_i("rst_no_fill", int'(cache_mem_write_en), 0);
        chk_i("rst_ready", int'(cpu_req_ready), 1);
        chk_i("rst_hits", int'(hit_count), 0);
        chk_i("rst_misses", int'(miss_count), 0);
        chk_i("rst_mem_req", int'(mem_req_valid), 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        chk_i("rst_still_idle", int'(cpu_req_ready), 1);
        chk_i("rst_no_resp", int'(cpu_resp_valid), 0);
        tick();

        // Back-to-back hits with cpu_req_valid held high.
        k = 0; nresp = 0; last = -1;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h1040;
        for (int c = 0; c < 100 && nresp < 16; c++) begin
            #1;
            if (cpu_resp_valid) begin
                if (last >= 0) chk_i($sformatf("b2b_gap%0d", nresp), c - last, 3);
                chk_l($sformatf("b2b_rdata%0d", nresp), cpu_resp_rdata,
                      nresp[0] ? mempat(32'h5100) : {64{8'h3C}});
                last = c; nresp++;
            end
            accepted = cpu_req_ready && cpu_req_valid;
            tick();
            if (accepted) begin
                k++;
                if (k == 16) cpu_req_valid = 1'b0;
                cpu_req_addr = k[0] ? 32'h5100 : 32'h1040;
            end
        end
        cpu_req_valid = 1'b0;
        #1;
        chk_i("b2b_responses", nresp, 16);
        chk_i("b2b_hits", int'(hit_count), 16);
        chk_i("b2b_misses", int'(miss_count), 0);
        tick();

        // Random traffic on lines in sets 32..47, untouched by the directed tests.
        m_hits = 16; m_miss = 0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0]  a, line;
            logic [511:0] wd, exp_rd;
            logic         w;
            int           r, s, eidx;
            bit           pres;
            eidx = int'($urandom_range(0, 15));
            a    = 32'h3800 + 32'(eidx) * 32'd64 + 32'($urandom_range(0, 63));
            line = a & ~32'h3F;
            w    = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 3));
            s    = int'($urandom_range(0, 3));
            for (int j = 0; j < 16; j++) wd[j*32 +: 32] = $urandom();
            pres = m_present.exists(line);
            if (w) exp_rd = '0;
            else if (m_data.exists(line)) exp_rd = m_data[line];
            else exp_rd = mempat(line);
            run_req(w, a, wd, r, s, 1'b0, 1'b0, rdata, lat, nfill, nhs, nreq, maddr, okf, wok);
            if (pres) m_hits++; else m_miss++;
            m_present[line] = 1'b1;
            if (w) m_data[line] = wd;
            chk_l($sformatf("rnd%0d_rdata", n), rdata, exp_rd);
            chk_i($sformatf("rnd%0d_latency", n), lat, pres ? 2 : 5 + r + s);
            chk_i($sformatf("rnd%0d_fill", n), nfill, pres ? 0 : 1);
            chk_i($sformatf("rnd%0d_maddr", n), int'(maddr), pres ? 0 : int'(line));
            chk_i($sformatf("rnd%0d_flags", n), int'(okf & wok), 1);
            chk_i($sformatf("rnd%0d_hits", n), int'(hit_count), m_hits);
            chk_i($sformatf("rnd%0d_misses", n), int'(miss_count), m_miss);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM in front of the line cache: accepts one line-granular CPU request at a time, runs tag lookup, serves hits, and fetches missing lines from backing memory before replaying the lookup. Sits between the pipeline's memory stage and the cache/memory interface. Owns every cache control strobe (`mem_write_en`, `cpu_write_en`), the cache address and cache write data. Also keeps hit/miss performance counters.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `LINE_SIZE`, 64: line size in bytes. Must match the cache. `NOFFSET = $clog2(LINE_SIZE)`.

Ports (all synchronous to `clock`):
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req_valid` in 1: CPU request present.
- `cpu_req_ready` out 1: controller can accept a request.
- `cpu_req_write` in 1: 1 = line write, 0 = line read.
- `cpu_req_addr` in XLEN: byte address.
- `cpu_req_wdata` in 8*LINE_SIZE: write line.
- `cpu_resp_valid` out 1: one-cycle completion pulse.
- `cpu_resp_rdata` out 8*LINE_SIZE: read line, valid with the pulse. Value is 0 for writes.
- `mem_req_valid` out 1: line fetch request.
- `mem_req_ready` in 1: memory accepts the fetch.
- `mem_req_addr` out XLEN: line-aligned fetch address.
- `mem_resp_valid` in 1: fetched line present, one cycle.
- `mem_resp_data` in 8*LINE_SIZE: fetched line.
- `cache_mem_write_en` out 1: drives cache `mem_write_en`.
- `cache_cpu_write_en` out 1: drives cache `cpu_write_en`.
- `cache_address` out XLEN: drives cache `address`.
- `cache_data_in` out 8*LINE_SIZE: drives cache `data_in`.
- `cache_data_out` in 8*LINE_SIZE: from cache. Registered, so it is valid one cycle after the address is presented.
- `cache_hit` in 1: from cache. Combinational on `cache_address`.
- `hit_count` out 32: number of lookups that hit.
- `miss_count` out 32: number of lookups that missed.

## Operation
Request handling:
- On acceptance (`cpu_req_valid && cpu_req_ready`), latch addr, write and wdata into request registers. The controller holds these registers until the response.
- `cache_address` is the latched address in every state except IDLE. In IDLE it is the incoming `cpu_req_addr`.

States:
- **IDLE**: `cpu_req_ready=1`. On acceptance, go to LOOKUP.
- **LOOKUP**: sample `cache_hit`.
  - Hit and read: go to READ.
  - Hit and write: go to WRITE.
  - Miss: go to FILL_REQ.
  - On every LOOKUP after a request is accepted, increment exactly one of `hit_count` or `miss_count`.
- **READ**: `cpu_resp_valid=1`, `cpu_resp_rdata=cache_data_out`. Go to IDLE.
- **WRITE**: `cache_cpu_write_en=1`, `cache_data_in` = latched wdata, `cpu_resp_valid=1`. Go to IDLE.
- **FILL_REQ**: `mem_req_valid=1`, `mem_req_addr` = latched address with bits [NOFFSET-1:0] cleared. Hold until `mem_req_ready`, then go to FILL_WAIT.
- **FILL_WAIT**: wait for `mem_resp_valid`. In that cycle drive `cache_mem_write_en=1` and `cache_data_in=mem_resp_data`, then go to REPLAY.
- **REPLAY**: identical to LOOKUP, except the counters do not change. A replay is guaranteed to hit because the line was just installed.

Other rules:
- Victim selection belongs to the cache. This revision has no dirty-line writeback.
- `cache_mem_write_en` and `cache_cpu_write_en` are never high in the same cycle.
- Counters wrap modulo 2^32.

## Timing
- Reset values: `cpu_req_ready=1`, all other outputs 0, counters 0, state IDLE.
- Read hit: accept at cycle T, LOOKUP at T+1, `cpu_resp_valid` at T+2.
- Write hit: `cpu_resp_valid` and `cache_cpu_write_en` both at T+2.
- Miss: `mem_req_valid` from T+2.
  - If the response arrives at cycle F, REPLAY is at F+1.
  - Response is at F+2 (READ or WRITE).
- `mem_req_valid` stays high with a stable address until `mem_req_ready`. It drops the cycle after the handshake.
- `mem_resp_valid` is ignored outside FILL_WAIT, including a response in the same cycle as the request handshake.
- `cpu_req_valid` while busy: `cpu_req_ready=0`. Nothing is latched.
- Reset in any state: next cycle is IDLE and all strobes are 0. A memory response still in flight after reset is ignored. Counters clear.

## Structure
- Package `cache_pkg` holds:
  - the state encoding localparams (IDLE, LOOKUP, READ, WRITE, FILL_REQ, FILL_WAIT, REPLAY);
  - a `line_align(addr)` function.
- One sub-module, `perf_counter`: 32-bit counter with sync reset and increment enable. It is instantiated twice, for hits and misses.
- Expected size is about 200 lines of RTL.

## Test plan
1. Read miss then read: read 0x1044 to memory model returning line 0xA5…A5.
   - Required: `mem_req_addr=0x1040`, one `cache_mem_write_en`, response 0xA5…A5.
   - Counters: `miss_count=1`, `hit_count=0`.
   - Re-read 0x1070: response at T+2 with no memory request, `hit_count=1`.
2. Write hit: after test 1, write 0x1040 with 0x3C…3C.
   - Required: `cache_cpu_write_en` and `cpu_resp_valid` at T+2, `cpu_resp_rdata=0`.
   - A following read of 0x1040 returns 0x3C…3C.
3. Memory backpressure: hold `mem_req_ready=0` for 5 cycles.
   - Required: `mem_req_valid` stable for 6 cycles with an unchanged address.
   - `cpu_req_ready=0` throughout, even with `cpu_req_valid=1`.
4. Spurious response: pulse `mem_resp_valid` in IDLE and again during FILL_REQ.
   - Required: no `cache_mem_write_en` and no state change.
5. Reset mid-fill: assert `reset` in FILL_WAIT, then deliver `mem_resp_valid` the following cycle.
   - Required: IDLE, no cache write, counters 0, `cpu_req_ready=1`.
6. Back-to-back reads: 16 hits with `cpu_req_valid` held high.
   - Required: one response every 3 cycles, `hit_count=16`.
